read_port_arbiter: RTL
======================

# read_port_arbiter

Round-robin arbiter that shares one 32-to-1, 32-bit selector (the existing `mux_32` in the ALU/regfile read path) among `NUM_REQ` requesters. Each requester posts a one-cycle read pulse with a 5-bit index. The arbiter buffers one outstanding request per requester, grants fairly, and drives the selector. It returns the selected word with a one-hot acknowledge. It sits between the pipeline-stage read clients and the shared word selector.

## Interface
- `NUM_REQ`, default 4: number of requesters, from 2 to 8.
- `IDX_W`, default 3: width of requester index; must satisfy `2**IDX_W >= NUM_REQ`.
- `clock` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-low; sampled on the `clock` rising edge.
- `data_in` in 1024: 32 words flattened; word i is `data_in[32*i+31:32*i]`.
- `req` in NUM_REQ: one-cycle read-request pulse per requester.
- `req_addr` in 5*NUM_REQ: word index for requester r at `[5*r+4:5*r]`; sampled only when `req[r]` is high.
- `ack` out NUM_REQ: one-hot, one-cycle pulse; marks `rdata` valid for that requester.
- `rdata` out 32: selected word; holds its value between acks.
- `busy` out NUM_REQ: pending bit per requester; high from capture until grant.
- `overflow` out 1: sticky error flag; set when `req[r]` pulses while `busy[r]` is already high.

## Operation
- Per-requester buffer: `pending[r]` and `addr_q[r]`.
  - When `req[r]` is high and `pending[r]` is low: set `pending[r]` and latch `req_addr[r]`.
  - When `req[r]` is high and `pending[r]` is high: ignore the request, keep the old address, set `overflow`.
- FSM has two states.
  - IDLE: if any `pending` bit is set, pick winner w by round-robin. Load `sel_q <= addr_q[w]` and `owner_q <= w`, clear `pending[w]`, go to READ. Otherwise stay in IDLE.
  - READ: `rdata <= word[sel_q]`, assert `ack[owner_q]` for one cycle, set `ptr <= owner_q + 1` (mod NUM_REQ), go to IDLE.
- Round-robin rule: search starts at `ptr`, wraps modulo NUM_REQ, and the first pending requester wins. After reset `ptr = 0`.
- A requester may re-request on any cycle after its pending bit clears, including the cycle its ack is high.
- Capture and grant on the same edge, for the same requester: impossible, because a re-request only follows clearing.
- Capture and grant on the same edge, for different requesters: both happen.
- Selector output is `data_in` word `sel_q`. It is combinational through `mux_32` and registered into `rdata` only in READ.
- Reset (reset=0 at an edge) forces:
  - state IDLE, `pending` all 0, `ptr` 0, `sel_q` 0, `owner_q` 0;
  - `ack` 0, `rdata` 0, `overflow` 0.
- Reset mid-operation drops all pending and in-flight requests with no ack. Requests pulsed during reset are discarded.

## Timing
- Request pulse at edge k → captured at k.
- Grant at edge k+1 if IDLE.
- `ack` and `rdata` are registered at edge k+2 and visible during cycle k+2 to k+3.
- Minimum latency from request to ack is 2 cycles.
- Throughput is one grant per 2 cycles. With all NUM_REQ requesters pending, worst-case wait is 2*NUM_REQ cycles.
- `data_in` must be stable in the cycle the FSM is in READ. Its value at that edge is returned.
- `busy[r]` is registered: rises the cycle after capture, falls the cycle after grant.
- `ack` is never high for two requesters at once and never for two consecutive cycles.

## Structure
- Shared package `arb_pkg`:
  - state encoding constants `ST_IDLE=1'b0`, `ST_READ=1'b1`;
  - word width 32 and index width 5 as constants.
- Sub-module `rr_pick`: combinational round-robin priority picker. Inputs are `pending` and `ptr`; outputs are `grant_valid` and `grant_idx`.
- Instantiate the existing `mux_32` unmodified as the selector. No other sub-modules.

## Test plan
For all scenarios, `data_in` word i = 32'd(i+100).
- Single request: `req[2]` pulses with addr 5 at edge k → `ack=4'b0100` and `rdata=105` during cycle k+2; `busy[2]` high for exactly 1 cycle.
- Simultaneous requests: `req[0..3]` with addr 0, 1, 2, 3 on one edge, after reset → acks in order 0,1,2,3 at k+2, k+4, k+6, k+8; rdata 100, 101, 102, 103.
- Fairness and wrap: after granting 3, `req[3]` and `req[1]` arrive together → 1 is granted before 3. Then `req[0]` and `req[3]` arrive → 0 is granted first, because `ptr` wrapped to 0 after the grant of 3.
- Overflow: `req[1]` with addr 7, then `req[1]` with addr 9 while `busy[1]` is high → `overflow=1` and stays set; ack returns 107; addr 9 is never served.
- Re-request on ack: `req[2]` re-pulses with addr 31 during its ack cycle → second ack 2 cycles later with rdata 131.
- Reset mid-flight: 3 requests pending, reset=0 for 1 cycle → no acks, `busy` all 0, `rdata`=0, `overflow`=0. The next request is granted starting from requester 0.

Source files
------------

// File: rtl/arb_pkg.sv
// arb_pkg: shared constants and FSM encoding for the read port arbiter.
package arb_pkg;
   localparam int WORD_W = 32;
   localparam int SEL_W = 5;
   typedef enum logic {ST_IDLE = 1'b0, ST_READ = 1'b1} state_t;
endpackage

// File: rtl/mux_32.sv
// mux_32: 32-to-1 selector of 32-bit words from a flattened bus.
module mux_32 (
   input  logic [1023:0] data_in,
   input  logic [4:0]    sel,
   output logic [31:0]   data_out
);
   assign data_out = data_in[{sel, 5'b0} +: 32];
endmodule

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker; the pending requester closest after ptr wins.
module rr_pick #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W = 3
) (
   input  logic [NUM_REQ-1:0] pending,
   input  logic [IDX_W-1:0]   ptr,
   output logic               grant_valid,
   output logic [IDX_W-1:0]   grant_idx
);
   int best;
   int off;
   always_comb begin
      grant_valid = |pending;
      grant_idx = '0;
      best = NUM_REQ;
      off = 0;
      for (int j = 0; j < NUM_REQ; j++) begin
         off = (j + NUM_REQ - int'(ptr)) % NUM_REQ;
         if (pending[j] && off < best) begin
            best = off;
            grant_idx = IDX_W'(j);
         end
      end
   end
endmodule

// File: rtl/read_port_arbiter.sv
// read_port_arbiter: shares one mux_32 among NUM_REQ requesters, one buffered request each,
// granted round-robin and answered with a one-hot ack and a registered word.
module read_port_arbiter
   import arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int IDX_W = 3
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [1023:0]            data_in,
   input  logic [NUM_REQ-1:0]       req,
   input  logic [SEL_W*NUM_REQ-1:0] req_addr,
   output logic [NUM_REQ-1:0]       ack,
   output logic [WORD_W-1:0]        rdata,
   output logic [NUM_REQ-1:0]       busy,
   output logic                     overflow
);
   state_t state, next_state;
   logic [NUM_REQ-1:0] pending, set, clr;
   logic [SEL_W-1:0] addr_q [2**IDX_W];
   logic [SEL_W-1:0] sel_q;
   logic [IDX_W-1:0] owner_q, ptr, grant_idx;
   logic grant_valid, grant;
   logic [WORD_W-1:0] word;

   rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
      .pending(pending),
      .ptr(ptr),
      .grant_valid(grant_valid),
      .grant_idx(grant_idx)
   );

   mux_32 u_mux (
      .data_in(data_in),
      .sel(sel_q),
      .data_out(word)
   );

   always_ff @(posedge clock)
      state <= !reset ? ST_IDLE : next_state;

   always_comb begin
      grant = (state == ST_IDLE) && grant_valid;
      next_state = grant ? ST_READ : ST_IDLE;
   end

   // a requester can never be captured and granted on one edge: capture needs pending low
   assign set = req & ~pending;
   assign clr = grant ? NUM_REQ'(1) << grant_idx : '0;
   assign busy = pending;

   always_ff @(posedge clock) begin
      if (!reset) begin
         pending <= '0;
         ptr <= '0;
         sel_q <= '0;
         owner_q <= '0;
         ack <= '0;
         rdata <= '0;
         overflow <= 1'b0;
         for (int r = 0; r < 2**IDX_W; r++) addr_q[r] <= '0;
      end else begin
         pending <= (pending & ~clr) | set;
         overflow <= overflow | (|(req & pending));
         for (int r = 0; r < NUM_REQ; r++)
            if (set[r]) addr_q[r] <= req_addr[SEL_W*r +: SEL_W];
         if (grant) begin
            sel_q <= addr_q[grant_idx];
            owner_q <= grant_idx;
         end
         ack <= (state == ST_READ) ? NUM_REQ'(1) << owner_q : '0;
         if (state == ST_READ) begin
            rdata <= word;
            ptr <= (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
         end
      end
   end
endmodule
